// File: rtl/counter_sequencer.sv
// counter_sequencer: control FSM for a 4-bit loadable counter with limit compare.
// On an accepted start it loads the counter once, then counts the rising edges
// of the counter's terminal-count flag as rounds. It returns to idle after the
// requested number of rounds, or earlier on abort.
module counter_sequencer #(
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         start_val,
    input  logic [3:0]         limit,
    input  logic [ROUND_W-1:0] rounds,
    input  logic               pause,
    input  logic               abort,
    input  logic               cnt_tc,
    output logic               cnt_load,
    output logic               cnt_en,
    output logic [3:0]         cnt_b,
    output logic [3:0]         cnt_l,
    output logic               busy,
    output logic               done,
    output logic [ROUND_W-1:0] round_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic               cnt_load_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [3:0]         cnt_b_reg;
    logic [3:0]         cnt_l_reg;
    logic [ROUND_W-1:0] rounds_reg;
    logic [ROUND_W-1:0] round_cnt_reg;
    logic               tc_prev_reg;

    logic               tc_rise;
    logic [ROUND_W-1:0] round_inc;

    // A round finishes only on a rising edge of cnt_tc, so a counter parked at
    // its limit (for example while paused) is counted once.
    assign tc_rise   = cnt_tc & ~tc_prev_reg;
    assign round_inc = round_cnt_reg + ROUND_W'(1);

    // Enable must react to pause in the same cycle, so it is decoded from state.
    assign cnt_en = (state_reg == S_LOAD) | ((state_reg == S_RUN) & ~pause);

    // Sequencer state, captured parameters and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_load_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            cnt_b_reg     <= '0;
            cnt_l_reg     <= '0;
            rounds_reg    <= '0;
            round_cnt_reg <= '0;
            tc_prev_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cnt_b_reg     <= start_val;
                        cnt_l_reg     <= limit;
                        rounds_reg    <= rounds;
                        round_cnt_reg <= '0;
                        tc_prev_reg   <= 1'b0;
                        if (rounds == '0) begin
                            // Nothing to run: report completion right away.
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg    <= S_LOAD;
                            cnt_load_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    cnt_load_reg <= 1'b0;
                    if (abort) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    tc_prev_reg <= cnt_tc;
                    // A completing edge is still counted when abort wins.
                    if (tc_rise) begin
                        round_cnt_reg <= round_inc;
                    end
                    if (abort) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (tc_rise && (round_inc == rounds_reg)) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign cnt_load  = cnt_load_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign cnt_b     = cnt_b_reg;
    assign cnt_l     = cnt_l_reg;
    assign round_cnt = round_cnt_reg;

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer. It pairs the sequencer with a behavioural
// 4-bit counter and checks every cycle against a sequence-level reference
// model. Directed checks with hand-computed cycle numbers pin that model.
module tb_counter_sequencer;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    start_val = '0;
    logic [3:0]    limit = '0;
    logic [RW-1:0] rounds = '0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic          cnt_tc;
    logic          cnt_load;
    logic          cnt_en;
    logic [3:0]    cnt_b;
    logic [3:0]    cnt_l;
    logic          busy;
    logic          done;
    logic [RW-1:0] round_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.ROUND_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_val (start_val),
        .limit     (limit),
        .rounds    (rounds),
        .pause     (pause),
        .abort     (abort),
        .cnt_tc    (cnt_tc),
        .cnt_load  (cnt_load),
        .cnt_en    (cnt_en),
        .cnt_b     (cnt_b),
        .cnt_l     (cnt_l),
        .busy      (busy),
        .done      (done),
        .round_cnt (round_cnt)
    );

    // Downstream counter: load wins, otherwise count and self-clear at the limit.
    logic [3:0] q;
    logic       tc_force = 1'b0;
    always @(posedge clk) begin
        if (rst)           q <= '0;
        else if (cnt_load) q <= cnt_b;
        else if (cnt_en)   q <= (q == cnt_l) ? 4'd0 : q + 4'd1;
    end
    assign cnt_tc = (q == cnt_l) | tc_force;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: a sequence is either inactive, active for m_age cycles
    // with m_left rounds still owed, or showing its completion cycle.
    bit       model_valid = 0;
    bit       m_active = 0;
    bit       m_done = 0;
    int       m_age = 0;
    int       m_left = 0;
    int       m_cnt = 0;
    bit       m_prev = 0;
    bit       m_hit = 0;
    int       m_b = 0;
    int       m_l = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_done = 0; m_age = 0; m_left = 0;
            m_cnt = 0; m_prev = 0; m_b = 0; m_l = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                m_b = start_val; m_l = limit; m_cnt = 0; m_prev = 0;
                if (rounds == 0) m_done = 1;
                else begin
                    m_active = 1; m_age = 1; m_left = rounds;
                end
            end
        end else begin
            if (m_age > 1) begin
                m_hit  = cnt_tc && !m_prev;
                m_prev = cnt_tc;
                if (m_hit) begin
                    m_cnt++;
                    m_left--;
                end
            end
            if (abort) m_active = 0;
            else if (m_left == 0) begin
                m_active = 0;
                m_done = 1;
            end
            m_age++;
        end
        model_valid = 1;
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_load",  cnt_load,  32'(m_active && m_age == 1));
            check("cmp_en",    cnt_en,    32'(m_active && (m_age == 1 || !pause)));
            check("cmp_busy",  busy,      32'(m_active));
            check("cmp_done",  done,      32'(m_done));
            check("cmp_round", round_cnt, 32'(m_cnt % (1 << RW)));
            check("cmp_b",     cnt_b,     32'(m_b));
            check("cmp_l",     cnt_l,     32'(m_l));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for one cycle; returns in cycle 1 after acceptance.
    task automatic do_start(input int sv, input int lim, input int rnd);
        start = 1'b1;
        start_val = 4'(sv);
        limit = 4'(lim);
        rounds = RW'(rnd);
        step();
        start = 1'b0;
    endtask

    logic [31:0] tc_mask;
    logic [31:0] done_mask;

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_b", cnt_b, 0);
        check("rst_round", round_cnt, 0);

        // Single round: 2 -> 5.
        do_start(2, 5, 1);
        check("single_load_c1", cnt_load, 1);
        step(); step(); step();
        check("single_tc_c4", cnt_tc, 0);
        step();
        check("single_tc_c5", cnt_tc, 1);
        check("single_done_c5", done, 0);
        step();
        check("single_done_c6", done, 1);
        check("single_round", round_cnt, 1);
        step();
        check("single_idle_c7", busy, 0);

        // Multi-round: terminal count at 5, 11, 17 and done at 18.
        tc_mask = '0;
        done_mask = '0;
        do_start(2, 5, 3);
        for (int c = 1; c <= 19; c++) begin
            if (c >= 2 && cnt_tc) tc_mask[c] = 1'b1;
            if (done) done_mask[c] = 1'b1;
            if (c == 18) check("multi_round", round_cnt, 3);
            step();
        end
        check("multi_tc_cycles", tc_mask, (32'd1 << 5) | (32'd1 << 11) | (32'd1 << 17));
        check("multi_done_cycle", done_mask, 32'd1 << 18);

        // Pause while the counter sits at its limit.
        do_start(2, 5, 3);
        step(); step(); step(); step();
        pause = 1'b1;
        tc_force = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("pause_en_low", cnt_en, 0);
            check("pause_tc_high", cnt_tc, 1);
            step();
        end
        pause = 1'b0;
        tc_force = 1'b0;
        check("pause_one_round", round_cnt, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("pause_abort_idle", busy, 0);

        // Abort in cycle 3 of a two-round run.
        do_start(2, 5, 2);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy_c4", busy, 0);
        check("abort_done_c4", done, 0);
        check("abort_round", round_cnt, 0);
        step();
        check("abort_done_c5", done, 0);

        // Zero rounds: immediate done, no load or enable.
        do_start(3, 9, 0);
        check("zero_done_c1", done, 1);
        check("zero_en_c1", cnt_en, 0);
        check("zero_load_c1", cnt_load, 0);
        check("zero_b", cnt_b, 3);
        step();
        check("zero_done_c2", done, 0);
        check("zero_en_c2", cnt_en, 0);

        // Start while busy is ignored.
        do_start(4, 9, 2);
        step(); step();
        start = 1'b1; start_val = 4'd1; limit = 4'd2; rounds = RW'(1);
        step();
        start = 1'b0;
        check("busy_start_b", cnt_b, 4);
        check("busy_start_l", cnt_l, 9);
        check("busy_start_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // start_val equals limit: round completes in the first RUN cycle.
        do_start(7, 7, 1);
        step();
        check("eq_tc_c2", cnt_tc, 1);
        step();
        check("eq_done_c3", done, 1);
        step();

        // Reset mid-run with a competing start.
        do_start(2, 5, 3);
        for (int c = 1; c < 8; c++) step();
        check("rst_mid_round", round_cnt, 1);
        rst = 1'b1;
        start = 1'b1; start_val = 4'd9; limit = 4'd12; rounds = RW'(2);
        step();
        rst = 1'b0;
        start = 1'b0;
        check("rst_mid_load", cnt_load, 0);
        check("rst_mid_en", cnt_en, 0);
        check("rst_mid_b", cnt_b, 0);
        check("rst_mid_l", cnt_l, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_round", round_cnt, 0);
        step();
        check("rst_mid_still_idle", busy, 0);

        // Randomized traffic, checked by the per-cycle compare.
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 2) == 0);
            start_val = 4'($urandom_range(0, 15));
            limit     = 4'($urandom_range(0, 15));
            rounds    = ($urandom_range(0, 19) == 0) ? RW'(15) : RW'($urandom_range(0, 4));
            pause     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            tc_force  = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            step();
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; tc_force = 1'b0; rst = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
